// File: rtl/sccb_responder.sv
// SCCB (OV7670-style) responder with a 256x8 register file and a backdoor read port.
// Define SCCB_AUTOINC_EN for pointer auto-increment and multi-byte write/read bursts.
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

`ifdef SCCB_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ID, ST_ID_ACK, ST_SUBADDR, ST_SUB_ACK, ST_WDATA,
    ST_WDATA_ACK, ST_WDATA_DONE, ST_RDATA, ST_RDATA_ACK, ST_RDATA_NEXT, ST_IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sioc_sync, siod_sync;
  logic                   scl_q, sda_q;
  logic [3:0]             bit_cnt;
  logic [7:0]             shift_q, ptr, rd_byte;
  logic                   is_read;
  logic [7:0]             regs [256];

  // Lines idle high, so synchronizers reset to 1 to avoid a phantom edge at release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sioc_sync <= '1;
      siod_sync <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
    end else begin
      sioc_sync <= {sioc_sync[SYNC_STAGES-2:0], sioc};
      siod_sync <= {siod_sync[SYNC_STAGES-2:0], siod_in};
      scl_q     <= sioc_sync[SYNC_STAGES-1];
      sda_q     <= siod_sync[SYNC_STAGES-1];
    end
  end

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;
  assign scl       = sioc_sync[SYNC_STAGES-1];
  assign sda       = siod_sync[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & ~sda & sda_q;
  assign stop_det  = scl & scl_q & sda & ~sda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shift_q  <= '0;
      ptr      <= '0;
      rd_byte  <= '0;
      is_read  <= 1'b0;
      siod_oe  <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < 256; i++) regs[i] <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state   <= ST_ID;
        bit_cnt <= '0;
        siod_oe <= 1'b0;
        busy    <= 1'b1;
      end else if (stop_det) begin
        state   <= ST_IDLE;
        siod_oe <= 1'b0;
        busy    <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ID, ST_SUBADDR, ST_WDATA, ST_WDATA_DONE:
            if (bit_cnt < 4'd8) begin
              shift_q <= {shift_q[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end
          ST_RDATA:
            if (bit_cnt < 4'd8) bit_cnt <= bit_cnt + 4'd1;
          ST_RDATA_ACK:
            state <= (!sda && AUTOINC) ? ST_RDATA_NEXT : ST_IGNORE;
          default: ;
        endcase
      end else if (scl_fall) begin
        // Every SIOD change happens here, while SIOC is low.
        case (state)
          ST_ID:
            if (bit_cnt == 4'd8) begin
              if (shift_q == DEVICE_ID || shift_q == READ_ID) begin
                siod_oe <= 1'b1;
                is_read <= (shift_q == READ_ID);
                state   <= ST_ID_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          ST_ID_ACK: begin
            bit_cnt <= '0;
            if (is_read) begin
              rd_byte <= regs[ptr];
              siod_oe <= ~regs[ptr][7];
              state   <= ST_RDATA;
            end else begin
              siod_oe <= 1'b0;
              state   <= ST_SUBADDR;
            end
          end
          ST_SUBADDR:
            if (bit_cnt == 4'd8) begin
              ptr     <= shift_q;
              siod_oe <= 1'b1;
              state   <= ST_SUB_ACK;
            end
          ST_SUB_ACK: begin
            siod_oe <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_WDATA;
          end
          ST_WDATA, ST_WDATA_DONE:
            if (bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ST_WDATA || AUTOINC) begin
                regs[ptr] <= shift_q;
                wr_valid  <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= shift_q;
                siod_oe   <= 1'b1;
                state     <= ST_WDATA_ACK;
                if (AUTOINC) ptr <= ptr + 8'd1;
              end
            end
          ST_WDATA_ACK: begin
            siod_oe <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_WDATA_DONE;
          end
          ST_RDATA:
            if (bit_cnt == 4'd8) begin
              siod_oe <= 1'b0;
              state   <= ST_RDATA_ACK;
              if (AUTOINC) ptr <= ptr + 8'd1;
            end else begin
              siod_oe <= ~rd_byte[3'd7 - bit_cnt[2:0]];
            end
          ST_RDATA_NEXT: begin
            rd_byte <= regs[ptr];
            siod_oe <= ~regs[ptr][7];
            bit_cnt <= '0;
            state   <= ST_RDATA;
          end
          default: siod_oe <= 1'b0;
        endcase
      end
    end
  end

  // Backdoor port samples the array before any same-clock write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dbg_data <= '0;
    else      dbg_data <= regs[dbg_addr];
  end

endmodule
